// File: rtl/sdram_arb_pkg.sv
// Shared types, widths and grant-selection helpers for the SDRAM request arbiter.
package sdram_arb_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_e;

    localparam int RAM_ADDR_W = 32;
    localparam int RAM_DATA_W = 32;
    localparam int RAM_LEN_W  = 8;
    localparam int RAM_STRB_W = 4;
    localparam int MAX_PORTS  = 4;

    // First requesting port after cur in circular order; cur itself is checked last.
    function automatic logic [1:0] arb_rr_next(input logic [1:0] cur,
                                               input logic [MAX_PORTS-1:0] req,
                                               input int n);
        logic [1:0] nxt;
        int         idx;
        nxt = cur;
        for (int k = MAX_PORTS; k >= 1; k--) begin
            if (k <= n) begin
                idx = (int'(cur) + k) % n;
                if (req[idx[1:0]]) nxt = idx[1:0];
            end
        end
        return nxt;
    endfunction

    function automatic logic [1:0] arb_fixed_next(input logic [1:0] cur,
                                                  input logic [MAX_PORTS-1:0] req,
                                                  input int n);
        logic [1:0] nxt;
        nxt = cur;
        for (int k = MAX_PORTS - 1; k >= 0; k--) begin
            if (k < n && req[2'(k)]) nxt = 2'(k);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Tag FIFO remembering which port owns each accepted, not-yet-acked request.
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i & ~empty_o;
    // A pop frees the slot in the same cycle, so push is allowed when full.
    assign push_ok = push_i & (~full_o | pop_ok);
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Round-robin arbiter sharing one SDRAM core request port, with burst lock and ack routing.
// Define SDRAM_ARB_FIXED_PRIO_EN to make port 0 the highest fixed priority instead.
module sdram_req_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int OUTSTANDING = 4,
    parameter int PORT_W      = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_PORTS*RAM_STRB_W-1:0]   inport_wr_i,
    input  logic [NUM_PORTS-1:0]              inport_rd_i,
    input  logic [NUM_PORTS*RAM_LEN_W-1:0]    inport_len_i,
    input  logic [NUM_PORTS*RAM_ADDR_W-1:0]   inport_addr_i,
    input  logic [NUM_PORTS*RAM_DATA_W-1:0]   inport_write_data_i,
    output logic [NUM_PORTS-1:0]              inport_accept_o,
    output logic [NUM_PORTS-1:0]              inport_ack_o,
    output logic [NUM_PORTS-1:0]              inport_error_o,
    output logic [RAM_DATA_W-1:0]             inport_read_data_o,
    output logic [RAM_STRB_W-1:0]             outport_wr_o,
    output logic                              outport_rd_o,
    output logic [RAM_LEN_W-1:0]              outport_len_o,
    output logic [RAM_ADDR_W-1:0]             outport_addr_o,
    output logic [RAM_DATA_W-1:0]             outport_write_data_o,
    input  logic                              outport_accept_i,
    input  logic                              outport_ack_i,
    input  logic                              outport_error_i,
    input  logic [RAM_DATA_W-1:0]             outport_read_data_i
);

    arb_state_e           state_q;
    logic [PORT_W-1:0]    gnt_q, gnt_d, head_tag;
    logic [RAM_LEN_W-1:0] beats_q, len_g;
    logic [NUM_PORTS-1:0] req;
    logic                 fifo_full, fifo_empty, fwd, acc, pop;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++)
            req[p] = (|inport_wr_i[p*RAM_STRB_W +: RAM_STRB_W]) | inport_rd_i[p];
    end

    assign len_g = inport_len_i[int'(gnt_q)*RAM_LEN_W +: RAM_LEN_W];

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    assign gnt_d = PORT_W'(arb_fixed_next(2'(gnt_q), 4'(req), NUM_PORTS));
`else
    assign gnt_d = PORT_W'(arb_rr_next(2'(gnt_q), 4'(req), NUM_PORTS));
`endif

    // Outputs are held at zero while reset is asserted, even mid-transfer.
    always_comb begin
        outport_wr_o         = '0;
        outport_rd_o         = 1'b0;
        outport_len_o        = '0;
        outport_addr_o       = '0;
        outport_write_data_o = '0;
        inport_accept_o      = '0;
        inport_ack_o         = '0;
        inport_error_o       = '0;
        inport_read_data_o   = '0;
        pop                  = 1'b0;
        if (!rst_i) begin
            if (!fifo_full) begin
                outport_wr_o = inport_wr_i[int'(gnt_q)*RAM_STRB_W +: RAM_STRB_W];
                outport_rd_o = inport_rd_i[gnt_q];
            end
            outport_len_o            = len_g;
            outport_addr_o           = inport_addr_i[int'(gnt_q)*RAM_ADDR_W +: RAM_ADDR_W];
            outport_write_data_o     = inport_write_data_i[int'(gnt_q)*RAM_DATA_W +: RAM_DATA_W];
            inport_accept_o[gnt_q]   = outport_accept_i & ~fifo_full;
            pop                      = outport_ack_i & ~fifo_empty;
            inport_ack_o[head_tag]   = pop;
            inport_error_o[head_tag] = pop & outport_error_i;
            inport_read_data_o       = outport_read_data_i;
        end
    end

    assign fwd = (|outport_wr_o) | outport_rd_o;
    assign acc = fwd & outport_accept_i;

    sdram_arb_tag_fifo #(
        .DEPTH (OUTSTANDING),
        .W     (PORT_W)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (acc),
        .data_i  (gnt_q),
        .pop_i   (pop),
        .data_o  (head_tag),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            beats_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (acc && len_g != '0) begin
                        state_q <= LOCKED;
                        beats_q <= len_g;
                    end else if (!req[gnt_q] || acc) begin
                        gnt_q <= gnt_d;
                    end
                end
                LOCKED: begin
                    // Remaining beats ignore len; the last one releases and re-arbitrates.
                    if (acc) begin
                        beats_q <= beats_q - RAM_LEN_W'(1);
                        if (beats_q == RAM_LEN_W'(1)) begin
                            state_q <= IDLE;
                            gnt_q   <= gnt_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Acks that trail a reset are legitimately dropped; only flag empty acks after new traffic.
    logic flushed_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)    flushed_q <= 1'b1;
        else if (acc) flushed_q <= 1'b0;
    end
    always @(posedge clk_i) begin
        if (!rst_i)
            assert (!(outport_ack_i && fifo_empty && !flushed_q))
                else $error("ack received with no outstanding request");
    end
`endif

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Randomised and directed bench for sdram_req_arbiter with a tag scoreboard.
module tb_sdram_req_arbiter;

    localparam int NP  = 2;
    localparam int OUT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP*4-1:0] in_wr;
    logic [NP-1:0]   in_rd;
    logic [NP*8-1:0] in_len;
    logic [NP*32-1:0] in_addr, in_wd;
    logic [NP-1:0]   inport_accept_o, inport_ack_o, inport_error_o;
    logic [31:0]     inport_read_data_o;
    logic [3:0]      outport_wr_o;
    logic            outport_rd_o;
    logic [7:0]      outport_len_o;
    logic [31:0]     outport_addr_o, outport_write_data_o;
    logic            acc_i, ack_i, err_i;
    logic [31:0]     rdata_i;

    always #5 clk = ~clk;

    sdram_req_arbiter #(.NUM_PORTS(NP), .OUTSTANDING(OUT), .PORT_W(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .inport_wr_i(in_wr), .inport_rd_i(in_rd), .inport_len_i(in_len),
        .inport_addr_i(in_addr), .inport_write_data_i(in_wd),
        .inport_accept_o(inport_accept_o), .inport_ack_o(inport_ack_o),
        .inport_error_o(inport_error_o), .inport_read_data_o(inport_read_data_o),
        .outport_wr_o(outport_wr_o), .outport_rd_o(outport_rd_o),
        .outport_len_o(outport_len_o), .outport_addr_o(outport_addr_o),
        .outport_write_data_o(outport_write_data_o),
        .outport_accept_i(acc_i), .outport_ack_i(ack_i),
        .outport_error_i(err_i), .outport_read_data_i(rdata_i)
    );

    // requester state: each request stays up until all len+1 beats are accepted
    bit          act [NP];
    bit          isw [NP];
    int          left[NP];
    logic [3:0]  strb[NP];
    logic [7:0]  len [NP];
    logic [31:0] addr[NP], wdat[NP];
    bit          gen_on[NP];
    int          p_new, p_acc, p_ack, p_err, gen_wr_pct, gen_len_max;
    bit          stray, fix_en;
    logic [31:0] fix_data;

    // reference model: current owner, burst beats still owed, outstanding count
    int m_gnt, m_out, m_burst;
    bit m_locked;
    int exp_q[$];
    int acc_log[$], ack_log[$];
    int ack_seen[NP], err_seen[NP];
    int passed = 0, total = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic apply_inputs();
        for (int p = 0; p < NP; p++) begin
            in_rd[p]          = act[p] && !isw[p];
            in_wr[p*4 +: 4]   = (act[p] && isw[p]) ? strb[p] : 4'h0;
            in_len[p*8 +: 8]  = len[p];
            in_addr[p*32 +: 32] = addr[p];
            in_wd[p*32 +: 32] = wdat[p];
        end
    endtask

    task automatic new_req(input int p, input bit w, input int ln, input logic [31:0] a);
        act[p]  = 1'b1;
        isw[p]  = w;
        strb[p] = w ? 4'($urandom_range(15, 1)) : 4'h0;
        len[p]  = 8'(ln);
        left[p] = ln + 1;
        addr[p] = a;
        wdat[p] = $urandom;
    endtask

    // who should own the port next, given who is asking right now
    function automatic int next_owner(input int g);
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        for (int p = 0; p < NP; p++) if (act[p]) return p;
        return g;
`else
        for (int k = 1; k <= NP; k++) if (act[(g + k) % NP]) return (g + k) % NP;
        return g;
`endif
    endfunction

    task automatic model_cycle();
        int g, obs;
        bit full, fwd, acc, pop, erd;
        logic [3:0]    ewr;
        logic [NP-1:0] eacc;
        g    = m_gnt;
        full = (m_out == OUT);
        erd  = act[g] && !isw[g] && !full;
        ewr  = (act[g] && isw[g] && !full) ? strb[g] : 4'h0;
        eacc = '0;
        if (acc_i && !full) eacc[g] = 1'b1;
        check("req_path", {outport_rd_o, outport_wr_o, inport_accept_o}, {erd, ewr, eacc});
        fwd = erd || (ewr != 4'h0);
        if (fwd) begin
            check("req_fields", {outport_addr_o, outport_len_o}, {addr[g], len[g]});
            if (isw[g]) check("req_wdata", outport_write_data_o, wdat[g]);
        end
        obs = -1;
        for (int p = 0; p < NP; p++) if (inport_accept_o[p]) obs = p;
        if ((outport_rd_o || |outport_wr_o) && obs >= 0) acc_log.push_back(obs);
        acc = fwd && acc_i;
        pop = ack_i && (m_out > 0);
        if (acc) exp_q.push_back(g);
        if (m_locked) begin
            if (acc) begin
                m_burst--;
                if (m_burst == 0) begin
                    m_locked = 1'b0;
                    m_gnt    = next_owner(g);
                end
            end
        end else if (acc && len[g] != 8'd0) begin
            m_locked = 1'b1;
            m_burst  = int'(len[g]);
        end else if (!act[g] || acc) begin
            m_gnt = next_owner(g);
        end
        m_out = m_out + int'(acc) - int'(pop);
        if (acc) begin
            left[g]--;
            if (left[g] == 0) act[g] = 1'b0;
            else begin
                addr[g] += 32'd4;
                wdat[g] = $urandom;
                len[g]  = 8'($urandom);
            end
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        for (int p = 0; p < NP; p++)
            if (gen_on[p] && !act[p] && $urandom_range(99) < p_new)
                new_req(p, $urandom_range(99) < gen_wr_pct, $urandom_range(gen_len_max),
                        $urandom & 32'hFFFF_FFFC);
        apply_inputs();
        acc_i   = $urandom_range(99) < p_acc;
        ack_i   = ((m_out > 0) && ($urandom_range(99) < p_ack)) || stray;
        err_i   = ack_i && ($urandom_range(99) < p_err);
        rdata_i = fix_en ? fix_data : $urandom;
        @(negedge clk); #2;
        model_cycle();
    endtask

    task automatic do_reset(input bit chk);
        rst = 1'b1;
        #1;
        if (chk) begin
            check("reset_in_outs", {inport_accept_o, inport_ack_o, inport_error_o, inport_read_data_o}, '0);
            check("reset_out_outs", {outport_wr_o, outport_rd_o, outport_len_o, outport_addr_o,
                                     outport_write_data_o}, '0);
        end
        for (int p = 0; p < NP; p++) act[p] = 1'b0;
        apply_inputs();
        acc_i = 1'b0; ack_i = 1'b0; err_i = 1'b0;
        m_gnt = 0; m_out = 0; m_locked = 1'b0; m_burst = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        acc_log.delete();
        ack_log.delete();
        for (int p = 0; p < NP; p++) begin
            ack_seen[p] = 0;
            err_seen[p] = 0;
        end
    endtask

    // scoreboard monitor: every ack the DUT presents is matched against the oldest accept
    initial begin
        int p, obs;
        logic [NP-1:0] eack, eerr;
        forever begin
            @(negedge clk);
            if (!rst) begin
                obs = -1;
                for (int i = 0; i < NP; i++) begin
                    if (inport_ack_o[i]) begin ack_seen[i]++; obs = i; end
                    if (inport_error_o[i]) err_seen[i]++;
                end
                if (obs >= 0) ack_log.push_back(obs);
                if (ack_i && exp_q.size() > 0) begin
                    p    = exp_q.pop_front();
                    eack = '0;
                    eack[p] = 1'b1;
                    eerr = err_i ? eack : '0;
                    check("ack_route", {inport_ack_o, inport_error_o, inport_read_data_o},
                          {eack, eerr, rdata_i});
                end else if (ack_i || |inport_ack_o) begin
                    check("stray_ack", {inport_ack_o, inport_error_o}, '0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int rr_exp[4];
        int burst_exp[5];
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        rr_exp = '{0, 0, 0, 0};
`else
        rr_exp = '{0, 1, 0, 1};
`endif
        burst_exp = '{0, 0, 0, 0, 1};
        for (int p = 0; p < NP; p++) begin
            act[p] = 0; isw[p] = 0; left[p] = 0; strb[p] = 0; len[p] = 0;
            addr[p] = 0; wdat[p] = 0; gen_on[p] = 0;
        end
        p_new = 0; p_acc = 0; p_ack = 0; p_err = 0; gen_wr_pct = 50; gen_len_max = 0;
        stray = 0; fix_en = 0; fix_data = 0; rdata_i = 32'hA5A5_5A5A;
        in_wr = '0; in_rd = '0; in_len = '0; in_addr = '0; in_wd = '0;
        acc_i = 1'b1; ack_i = 1'b0; err_i = 1'b0;
        do_reset(1);

        // single read from port 1
        clear_logs();
        new_req(1, 1'b0, 0, 32'h100);
        fix_en = 1; fix_data = 32'hDEADBEEF;
        repeat (2) step();
        p_acc = 100; step(); p_acc = 0;
        repeat (2) step();
        p_ack = 100; step(); p_ack = 0;
        repeat (2) step();
        fix_en = 0;
        check("single_acc_count", acc_log.size(), 1);
        check("single_acc_port", acc_log.size() > 0 ? acc_log[0] : -1, 1);
        check("single_ack_p1", ack_seen[1], 1);
        check("single_ack_p0", ack_seen[0], 0);

        // both ports streaming single writes, everything accepted
        do_reset(0); clear_logs();
        gen_on[0] = 1; gen_on[1] = 1; p_new = 100; gen_wr_pct = 100; gen_len_max = 0;
        p_acc = 100; p_ack = 100;
        repeat (8) step();
        p_new = 0;
        repeat (8) step();
        for (int i = 0; i < 4; i++) begin
            check("rr_accept_order", i < acc_log.size() ? acc_log[i] : -1, rr_exp[i]);
            check("rr_ack_order", i < ack_log.size() ? ack_log[i] : -1, rr_exp[i]);
        end

        // burst lock
        do_reset(0); clear_logs();
        gen_on[0] = 0; gen_on[1] = 0;
        new_req(0, 1'b0, 3, 32'h2000);
        new_req(1, 1'b1, 0, 32'h3000);
        repeat (10) step();
        for (int i = 0; i < 5; i++)
            check("burst_order", i < acc_log.size() ? acc_log[i] : -1, burst_exp[i]);

        // fill the tag FIFO, then ack while requesting
        do_reset(0); clear_logs();
        gen_on[0] = 1; p_new = 100; gen_wr_pct = 0; gen_len_max = 0; p_acc = 100; p_ack = 0;
        repeat (7) step();
        check("full_accepts", acc_log.size(), OUT);
        check("full_blocks_rd", {outport_rd_o, outport_wr_o, inport_accept_o}, '0);
        p_ack = 100;
        repeat (2) step();
        p_ack = 0;
        repeat (2) step();
        check("refill_accepts", acc_log.size(), OUT + 2);
        check("refull_blocks_rd", {outport_rd_o, inport_accept_o}, '0);
        gen_on[0] = 0; p_new = 0; p_ack = 100;
        repeat (8) step();

        // error routed to port 1 for exactly one cycle
        do_reset(0); clear_logs();
        new_req(1, 1'b1, 0, 32'h40);
        p_acc = 100; p_ack = 0;
        repeat (3) step();
        p_err = 100; p_ack = 100; step();
        p_err = 0; p_ack = 0;
        repeat (2) step();
        check("err_cycles_p1", err_seen[1], 1);
        check("err_cycles_p0", err_seen[0], 0);

        // reset mid-burst with two outstanding, then a stray ack
        do_reset(0); clear_logs();
        new_req(0, 1'b0, 3, 32'h5000);
        new_req(1, 1'b1, 0, 32'h6000);
        p_acc = 100; p_ack = 0;
        repeat (2) step();
        check("midburst_accepts", acc_log.size(), 2);
        do_reset(1); clear_logs();
        p_acc = 0;
        stray = 1; step(); stray = 0;
        check("stray_dropped", {ack_seen[0], ack_seen[1]}, '0);

        // randomised traffic
        gen_on[0] = 1; gen_on[1] = 1;
        p_new = 40; p_acc = 60; p_ack = 45; p_err = 20; gen_wr_pct = 50; gen_len_max = 3;
        repeat (1500) step();
        p_new = 0; p_acc = 100; p_ack = 100;
        repeat (40) step();
        check("drain_empty", m_out, 0);
        check("drain_scoreboard", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
